// File: rtl/gate_sweep_checker_if.sv
// Gate self-test bus: control and results from the checker side,
// stimulus vector out to the gate and its response back in.
interface gate_sweep_checker_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic             start;
  logic [2:0]       op;
  logic [N_IN-1:0]  vec_out;
  logic             dut_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, op, dut_in,
    input  vec_out, busy, done, pass,
    input  err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, op, dut_in,
    output vec_out, busy, done, pass,
    output err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of one N_IN-input gate against a
// selectable reduction op; reports pass, error count, first failure.
module gate_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic clk,
  input  logic rst,
  gate_sweep_checker_if.slave bus
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};
  localparam logic [CW-1:0] CNT_END = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE, DRIVE, SAMPLE, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [N_IN:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic             ffok_q, ffok_d;
  logic             pass_q, pass_d;
  logic             exp_bit;
  logic             miss;

  function automatic logic ref_out(
    input logic [2:0]      o,
    input logic [N_IN-1:0] v
  );
    logic r;
    r = 1'b0;
    case (o)
      3'd0:    r = &v;
      3'd1:    r = |v;
      3'd2:    r = ~&v;
      3'd3:    r = ~|v;
      3'd4:    r = ^v;
      3'd5:    r = ~^v;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffok_d  = ffok_q;
    pass_d  = pass_q;
    exp_bit = ref_out(op_q, idx_q[N_IN-1:0]);
    miss    = (bus.dut_in != exp_bit);
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_d    = bus.op;
          idx_d   = '0;
          cnt_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffok_d  = 1'b0;
          pass_d  = 1'b0;
          // reserved ops finish at once with pass low
          state_d = (bus.op > 3'd5) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        if (miss) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (!ffok_q) begin
            ffv_d  = idx_q[N_IN-1:0];
            ffok_d = 1'b1;
          end
        end
        if (idx_q == LAST) begin
          state_d = DONE;
          pass_d  = (op_q <= 3'd5) && (err_d == '0);
        end else begin
          idx_d   = idx_q + (N_IN+1)'(1);
          vec_d   = idx_d[N_IN-1:0];
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffok_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffok_q  <= ffok_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.vec_out          = vec_q;
  assign bus.busy             = (state_q == DRIVE) || (state_q == SAMPLE);
  assign bus.done             = (state_q == DONE);
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffok_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: four checker configurations, directed sweeps,
// expected results queued at start and checked when done rises.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gate_sweep_checker_if #(.N_IN(2), .ERR_W(8)) ia ();
  gate_sweep_checker_if #(.N_IN(3), .ERR_W(8)) ib ();
  gate_sweep_checker_if #(.N_IN(4), .ERR_W(2)) ic ();
  gate_sweep_checker_if #(.N_IN(1), .ERR_W(8)) id ();

  gate_sweep_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  gate_sweep_checker #(.N_IN(3), .SETTLE(1), .ERR_W(8))
    u_b (.clk(clk), .rst(rst), .bus(ib));
  gate_sweep_checker #(.N_IN(4), .SETTLE(1), .ERR_W(2))
    u_c (.clk(clk), .rst(rst), .bus(ic));
  gate_sweep_checker #(.N_IN(1), .SETTLE(3), .ERR_W(8))
    u_d (.clk(clk), .rst(rst), .bus(id));

  int mode_a = 0;
  int mode_b = 0;
  assign ia.dut_in = (mode_a == 0) ? ~&ia.vec_out : 1'b1;
  assign ib.dut_in = (mode_b == 0) ? &ib.vec_out : 1'b0;
  assign ic.dut_in = ~&ic.vec_out;
  assign id.dut_in = ~id.vec_out[0];

  logic       done_w[4], busy_w[4], start_w[4];
  logic       pass_w[4], ffok_w[4];
  logic [7:0] err_w[4], ffv_w[4], vec_w[4];

  assign done_w[0] = ia.done;  assign done_w[1] = ib.done;
  assign done_w[2] = ic.done;  assign done_w[3] = id.done;
  assign busy_w[0] = ia.busy;  assign busy_w[1] = ib.busy;
  assign busy_w[2] = ic.busy;  assign busy_w[3] = id.busy;
  assign start_w[0] = ia.start; assign start_w[1] = ib.start;
  assign start_w[2] = ic.start; assign start_w[3] = id.start;
  assign pass_w[0] = ia.pass;  assign pass_w[1] = ib.pass;
  assign pass_w[2] = ic.pass;  assign pass_w[3] = id.pass;
  assign ffok_w[0] = ia.first_fail_valid;
  assign ffok_w[1] = ib.first_fail_valid;
  assign ffok_w[2] = ic.first_fail_valid;
  assign ffok_w[3] = id.first_fail_valid;
  assign err_w[0] = 8'(ia.err_count); assign err_w[1] = 8'(ib.err_count);
  assign err_w[2] = 8'(ic.err_count); assign err_w[3] = 8'(id.err_count);
  assign ffv_w[0] = 8'(ia.first_fail_vec);
  assign ffv_w[1] = 8'(ib.first_fail_vec);
  assign ffv_w[2] = 8'(ic.first_fail_vec);
  assign ffv_w[3] = 8'(id.first_fail_vec);
  assign vec_w[0] = 8'(ia.vec_out); assign vec_w[1] = 8'(ib.vec_out);
  assign vec_w[2] = 8'(ic.vec_out); assign vec_w[3] = 8'(id.vec_out);

  typedef struct {
    int   dut;
    logic pass;
    int   err;
    int   ffv;
    logic ffok;
    int   vec;
    int   lat;
  } exp_t;

  exp_t sbq[$];
  int   vexp[$];
  bit   trk = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(string nm, int act, int exp);
    n_tot = n_tot + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic exp_t mk(int k, logic p, int e, int fv,
                              logic fo, int v, int l);
    exp_t x;
    x.dut = k; x.pass = p; x.err = e; x.ffv = fv;
    x.ffok = fo; x.vec = v; x.lat = l;
    return x;
  endfunction

  int   cyc = 0;
  int   start_cyc[4];
  logic prev_done[4];
  logic prev_busy_a = 1'b0;
  logic [7:0] prev_vec_a = '0;

  initial begin
    for (int k = 0; k < 4; k++) begin
      start_cyc[k] = 0;
      prev_done[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++)
      if (start_w[k] && !busy_w[k]) start_cyc[k] <= cyc;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done_w[k] && !prev_done[k]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", k, -1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_dut", k, e.dut);
          chk("pass", int'(pass_w[k]), int'(e.pass));
          chk("err_count", int'(err_w[k]), e.err);
          chk("first_fail_vec", int'(ffv_w[k]), e.ffv);
          chk("first_fail_valid", int'(ffok_w[k]), int'(e.ffok));
          chk("vec_hold", int'(vec_w[k]), e.vec);
          chk("latency", cyc - start_cyc[k] - 1, e.lat);
        end
      end
      prev_done[k] <= done_w[k];
    end
    if (trk && ia.busy && (!prev_busy_a || vec_w[0] != prev_vec_a)) begin
      if (vexp.size() == 0) chk("vec_seq_extra", int'(vec_w[0]), -1);
      else chk("vec_seq", int'(vec_w[0]), vexp.pop_front());
    end
    prev_busy_a <= ia.busy;
    prev_vec_a  <= vec_w[0];
  end

  task automatic set_start(int k, logic s, logic [2:0] o);
    case (k)
      0: begin ia.start = s; ia.op = o; end
      1: begin ib.start = s; ib.op = o; end
      2: begin ic.start = s; ic.op = o; end
      default: begin id.start = s; id.op = o; end
    endcase
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(int k, logic [2:0] o, exp_t e);
    @(negedge clk);
    sbq.push_back(e);
    set_start(k, 1'b1, o);
    @(negedge clk);
    set_start(k, 1'b0, 3'd0);
    drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int k = 0; k < 4; k++) set_start(k, 1'b0, 3'd0);
    #1 rst = 1'b1;
    #1;
    chk("reset_a", int'({ia.vec_out, ia.busy, ia.done, ia.pass,
        ia.err_count, ia.first_fail_vec, ia.first_fail_valid}), 0);
    chk("reset_c", int'({ic.vec_out, ic.busy, ic.done, ic.pass,
        ic.err_count, ic.first_fail_vec, ic.first_fail_valid}), 0);
    @(negedge clk) rst = 1'b0;

    // reserved op from IDLE: done right after the start edge
    run(0, 3'd6, mk(0, 1'b0, 0, 0, 1'b0, 0, 0));

    // good NAND: vectors 0..3, done 8 clocks after start
    vexp = '{0, 1, 2, 3};
    trk  = 1'b1;
    run(0, 3'd2, mk(0, 1'b1, 0, 0, 1'b0, 3, 8));
    trk  = 1'b0;
    chk("vec_seq_left", vexp.size(), 0);

    // stuck-at-1 output fails only on vector 3
    mode_a = 1;
    run(0, 3'd2, mk(0, 1'b0, 1, 3, 1'b1, 3, 8));
    mode_a = 0;

    // second start and op change mid-sweep are ignored
    @(negedge clk);
    sbq.push_back(mk(0, 1'b1, 0, 0, 1'b0, 3, 8));
    set_start(0, 1'b1, 3'd2);
    @(negedge clk);
    set_start(0, 1'b0, 3'd2);
    repeat (3) @(negedge clk);
    set_start(0, 1'b1, 3'd0);
    @(negedge clk);
    set_start(0, 1'b0, 3'd0);
    drain();

    // async reset mid-sweep, then a clean restart
    @(negedge clk);
    set_start(0, 1'b1, 3'd2);
    @(negedge clk);
    set_start(0, 1'b0, 3'd2);
    n = 0;
    while (ia.vec_out != 2'd2 && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("reach_vec2", int'(ia.vec_out), 2);
    #2 rst = 1'b1;
    #1;
    chk("midreset_a", int'({ia.vec_out, ia.busy, ia.done, ia.pass,
        ia.err_count, ia.first_fail_vec, ia.first_fail_valid}), 0);
    @(negedge clk) rst = 1'b0;
    run(0, 3'd2, mk(0, 1'b1, 0, 0, 1'b0, 3, 8));

    // N_IN=3 XOR vs stuck-0: parity-1 vectors 1,2,4,7 fail
    mode_b = 1;
    run(1, 3'd4, mk(1, 1'b0, 4, 1, 1'b1, 7, 16));
    // N_IN=3 XOR vs AND gate: vectors 1,2,4 fail
    mode_b = 0;
    run(1, 3'd4, mk(1, 1'b0, 3, 1, 1'b1, 7, 16));

    // N_IN=4 AND vs NAND: 16 misses, 2-bit count saturates at 3
    run(2, 3'd0, mk(2, 1'b0, 3, 0, 1'b1, 15, 32));

    // N_IN=1, SETTLE=3: NOR is an inverter, XOR a buffer
    run(3, 3'd3, mk(3, 1'b1, 0, 0, 1'b0, 1, 8));
    run(3, 3'd4, mk(3, 1'b0, 2, 0, 1'b1, 1, 8));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
